// File: rtl/time_entry_loader.sv
// Keypad time-entry front end: shifts BCD digits in, strobes them into the timer chain on start.
// Optional build macro SEC_CLAMP_EN clamps seconds above 59 to 59 when loading.
module time_entry_loader (
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] keys,
    input  logic       start,
    input  logic       cancel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       loadn,
    output logic [2:0] digit_cnt,
    output logic       armed
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_ARMED = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  state_s;
    logic [15:0] digits_r;
    logic [15:0] digits_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_s;
    logic        loadn_r;
    logic        armed_r;
    logic [9:0]  keys_q_r;
    logic        first_r;
    logic        start_block_r;
    logic        start_block_s;
    logic [9:0]  press_s;
    logic        press_any_s;
    logic [3:0]  digit_s;
    logic        start_go_s;

    function automatic logic [3:0] lowest_digit(input logic [9:0] p);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (p[i]) begin
                d = 4'(i);
            end
        end
        return d;
    endfunction

    function automatic logic [15:0] clamp_secs(input logic [15:0] d);
`ifdef SEC_CLAMP_EN
        if (d[7:4] > 4'd5) begin
            return {d[15:8], 4'd5, 4'd9};
        end else begin
            return d;
        end
`else
        return d;
`endif
    endfunction

    // Keys already high on the first cycle after reset are only captured, never pressed.
    assign press_s     = keys & ~keys_q_r & ~{10{first_r}};
    assign press_any_s = |press_s;
    assign digit_s     = lowest_digit(press_s);
    // Start is a level, but after a load it stays locked out until seen low.
    assign start_go_s  = start & ~start_block_r;

    // Next-state, digit and count logic with priority cancel > start > press.
    always_comb begin
        state_s       = state_r;
        digits_s      = digits_r;
        cnt_s         = cnt_r;
        start_block_s = start_block_r & start;
        case (state_r)
            ST_IDLE: begin
                if (cancel) begin
                    digits_s = 16'h0000;
                    cnt_s    = 3'd0;
                end else if (press_any_s) begin
                    digits_s = {12'h000, digit_s};
                    cnt_s    = 3'd1;
                    state_s  = ST_ENTRY;
                end else begin
                    digits_s = 16'h0000;
                    cnt_s    = 3'd0;
                end
            end
            ST_ENTRY: begin
                if (cancel) begin
                    digits_s = 16'h0000;
                    cnt_s    = 3'd0;
                    state_s  = ST_IDLE;
                end else if (start_go_s) begin
                    digits_s      = clamp_secs(digits_r);
                    start_block_s = 1'b1;
                    state_s       = ST_LOAD;
                end else if (press_any_s && (cnt_r != 3'd4)) begin
                    digits_s = {digits_r[11:0], digit_s};
                    cnt_s    = cnt_r + 3'd1;
                end else begin
                    state_s = ST_ENTRY;
                end
            end
            ST_LOAD: begin
                if (cancel) begin
                    digits_s = 16'h0000;
                    cnt_s    = 3'd0;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (cancel) begin
                    digits_s = 16'h0000;
                    cnt_s    = 3'd0;
                    state_s  = ST_IDLE;
                end else if (start_go_s) begin
                    digits_s      = clamp_secs(digits_r);
                    start_block_s = 1'b1;
                    state_s       = ST_LOAD;
                end else if (press_any_s) begin
                    digits_s = {12'h000, digit_s};
                    cnt_s    = 3'd1;
                    state_s  = ST_ENTRY;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            default: begin
                digits_s = 16'h0000;
                cnt_s    = 3'd0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State, data and strobe registers; clr aborts a load strobe immediately.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r       <= ST_IDLE;
            digits_r      <= 16'h0000;
            cnt_r         <= 3'd0;
            loadn_r       <= 1'b1;
            armed_r       <= 1'b0;
            keys_q_r      <= 10'd0;
            first_r       <= 1'b1;
            start_block_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            digits_r      <= digits_s;
            cnt_r         <= cnt_s;
            loadn_r       <= (state_s != ST_LOAD);
            armed_r       <= (state_s == ST_ARMED);
            keys_q_r      <= keys;
            first_r       <= 1'b0;
            start_block_r <= start_block_s;
        end
    end

    assign min_tens  = digits_r[15:12];
    assign min_ones  = digits_r[11:8];
    assign sec_tens  = digits_r[7:4];
    assign sec_ones  = digits_r[3:0];
    assign loadn     = loadn_r;
    assign digit_cnt = cnt_r;
    assign armed     = armed_r;

endmodule

// File: tb/tb_time_entry_loader.sv
// Directed-vector bench for time_entry_loader; honours SEC_CLAMP_EN the same way as the design.
module tb_time_entry_loader;

    logic       clk;
    logic       clr;
    logic [9:0] keys;
    logic       start;
    logic       cancel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       loadn;
    logic [2:0] digit_cnt;
    logic       armed;
    logic [15:0] dig;

    int vectors;
    int miscompares;
    int low_cnt;

    time_entry_loader dut (
        .clk       (clk),
        .clr       (clr),
        .keys      (keys),
        .start     (start),
        .cancel    (cancel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .loadn     (loadn),
        .digit_cnt (digit_cnt),
        .armed     (armed)
    );

    assign dig = {min_tens, min_ones, sec_tens, sec_ones};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int d);
        keys = 10'd1 << d;
        tick();
        keys = 10'd0;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr    = 1'b1;
        keys   = 10'd0;
        start  = 1'b0;
        cancel = 1'b0;
        tick();
        tick();
        check("rst_digits", 32'(dig), 32'h0000);
        check("rst_cnt", 32'(digit_cnt), 32'd0);
        check("rst_loadn", 32'(loadn), 32'd1);
        check("rst_armed", 32'(armed), 32'd0);
        clr = 1'b0;
        tick();

        // basic entry and load
        press(1); press(2); press(3); press(0);
        check("entry_digits", 32'(dig), 32'h1230);
        check("entry_cnt", 32'(digit_cnt), 32'd4);
        start = 1'b1;
        tick();
        check("load_loadn", 32'(loadn), 32'd0);
        check("load_digits", 32'(dig), 32'h1230);
        start = 1'b0;
        tick();
        check("armed_loadn", 32'(loadn), 32'd1);
        check("armed_flag", 32'(armed), 32'd1);
        tick();
        check("armed_loadn2", 32'(loadn), 32'd1);

        // press in ARMED restarts entry
        press(8);
        check("rearm_digits", 32'(dig), 32'h0008);
        check("rearm_cnt", 32'(digit_cnt), 32'd1);
        check("rearm_armed", 32'(armed), 32'd0);
        start   = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (loadn == 1'b0) low_cnt++;
        end
        check("held_start_pulses", 32'(low_cnt), 32'd1);
        check("held_start_armed", 32'(armed), 32'd1);
        start = 1'b0;
        tick();

        // cancel, overflow, held key
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_digits", 32'(dig), 32'h0000);
        check("cancel_armed", 32'(armed), 32'd0);
        press(1); press(2); press(3); press(4); press(5);
        check("sat_digits", 32'(dig), 32'h1234);
        check("sat_cnt", 32'(digit_cnt), 32'd4);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        keys = 10'd1 << 7;
        for (int i = 0; i < 10; i++) tick();
        keys = 10'd0;
        tick();
        check("hold_digits", 32'(dig), 32'h0007);
        check("hold_cnt", 32'(digit_cnt), 32'd1);

        // start beats press in ENTRY
        start = 1'b1;
        keys  = 10'd1 << 4;
        tick();
        check("sp_loadn", 32'(loadn), 32'd0);
        check("sp_digits", 32'(dig), 32'h0007);
        start = 1'b0;
        keys  = 10'd0;
        tick();
        check("sp_cnt", 32'(digit_cnt), 32'd1);
        check("sp_armed", 32'(armed), 32'd1);

        // cancel beats start and press
        cancel = 1'b1;
        start  = 1'b1;
        keys   = 10'd1 << 4;
        tick();
        check("csp_loadn", 32'(loadn), 32'd1);
        check("csp_digits", 32'(dig), 32'h0000);
        check("csp_cnt", 32'(digit_cnt), 32'd0);
        cancel = 1'b0;
        start  = 1'b0;
        keys   = 10'd0;
        tick();
        check("csp_loadn2", 32'(loadn), 32'd1);
        check("csp_armed", 32'(armed), 32'd0);

        // lowest key index wins
        keys = 10'b0001100100;
        tick();
        keys = 10'd0;
        tick();
        check("multi_digits", 32'(dig), 32'h0002);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;

        // seconds clamp
        press(9); press(0);
        start = 1'b1;
        tick();
        check("clamp_loadn", 32'(loadn), 32'd0);
`ifdef SEC_CLAMP_EN
        check("clamp_digits", 32'(dig), 32'h0059);
`else
        check("clamp_digits", 32'(dig), 32'h0090);
`endif
        start = 1'b0;
        tick();
`ifdef SEC_CLAMP_EN
        check("clamp_held", 32'(dig), 32'h0059);
`else
        check("clamp_held", 32'(dig), 32'h0090);
`endif

        // cancel during LOAD: pulse completes then IDLE
        start = 1'b1;
        tick();
        check("reload_loadn", 32'(loadn), 32'd0);
        start  = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cl_loadn", 32'(loadn), 32'd1);
        check("cl_armed", 32'(armed), 32'd0);
        check("cl_digits", 32'(dig), 32'h0000);

        // clr during LOAD acts without a clock edge
        press(2); press(5);
        start = 1'b1;
        tick();
        check("pre_clr_loadn", 32'(loadn), 32'd0);
        #2;
        clr = 1'b1;
        #1;
        check("async_loadn", 32'(loadn), 32'd1);
        check("async_digits", 32'(dig), 32'h0000);
        check("async_cnt", 32'(digit_cnt), 32'd0);
        start = 1'b0;
        keys  = 10'd1 << 3;
        tick();
        clr = 1'b0;
        tick();
        tick();
        check("held_at_release_cnt", 32'(digit_cnt), 32'd0);
        check("held_at_release_dig", 32'(dig), 32'h0000);
        keys = 10'd0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/time_entry_loader.md
TIME_ENTRY_LOADER -- requirements
Module: time_entry_loader

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: clr  in  1  asynchronous active-high reset.
REQ-003 SHALL have port: keys  in  10  keypad digit lines, bit i = digit i pressed; already synchronised and debounced upstream.
REQ-004 SHALL have port: start  in  1  level, request to load entered time into timer counters.
REQ-005 SHALL have port: cancel  in  1  level, discard entry.
REQ-006 SHALL have port: min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD load data for the timer digit chain, held stable between loads.
REQ-007 SHALL have port: loadn  out  1  active-low synchronous load strobe to the timer digit counters.
REQ-008 SHALL have port: digit_cnt  out  3  number of digits entered (0..4).
REQ-009 SHALL have port: armed  out  1  high while loaded time awaits countdown.

Function
REQ-010 SHALL register keys each cycle (keys_q); press = keys & ~keys_q (rising edge only; held key enters one digit).
REQ-011 SHALL, when several press bits are set in one cycle, take the lowest index only.
REQ-012 SHALL shift an accepted digit in on the edge where press is detected: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit; digit_cnt+1.
REQ-013 SHALL ignore presses while digit_cnt==4 (no shift, no wrap; count saturates at 4).
REQ-014 SHALL implement FSM states IDLE, ENTRY, LOAD, ARMED.
REQ-015 IDLE: digits 0, digit_cnt 0; press -> ENTRY with digit shifted in; start ignored.
REQ-016 ENTRY: press -> shift per REQ-012/013; start -> LOAD.
REQ-017 LOAD: exactly one cycle, loadn=0, digits frozen; next state ARMED unconditionally.
REQ-018 ARMED: armed=1, digits held; press -> clear all digits, shift new digit in, digit_cnt=1, ENTRY; start -> LOAD again (reload same value).
REQ-019 SHALL drive loadn=1 in all states except LOAD.
REQ-020 SHALL apply cancel in any state: digits 0, digit_cnt 0, -> IDLE next cycle; a LOAD cycle in progress completes its loadn pulse, then goes to IDLE rather than ARMED.
REQ-021 SHALL use priority cancel > start > press within one cycle; lower-priority events in that cycle are discarded.
REQ-022 SHALL treat start as level: a start held across LOAD SHALL NOT retrigger until start is sampled low at least once.
REQ-023 SHALL treat digit values from keys as 0..9 only; all outputs always valid BCD.

Reset
REQ-024 SHALL, while clr=1, asynchronously force: state IDLE, all digits 0, digit_cnt 0, loadn 1, armed 0, keys_q 0, start history low.
REQ-025 SHALL, on clr assertion during LOAD, abort the strobe immediately (loadn returns to 1 asynchronously).
REQ-026 SHALL treat keys already high at clr release as not pressed (keys_q captures them first cycle).

Configuration
REQ-027 SHALL support macro SEC_CLAMP_EN.
REQ-028 With SEC_CLAMP_EN defined: on entry to LOAD, if sec_tens>5 then sec_tens=5 and sec_ones=9 (presented during the loadn=0 cycle and held after); minutes untouched.
REQ-029 Without SEC_CLAMP_EN: digits presented exactly as entered (e.g. 0:99 allowed).

Verification
REQ-030 Reset, press 1,2,3,0, start -> digits 1,2,3,0, digit_cnt 4, loadn low exactly one cycle, then armed=1.
REQ-031 Press 5 digits 1..5 -> digits 1,2,3,4, fifth ignored, digit_cnt 4; hold key 7 for 10 cycles in IDLE -> one digit 7 only.
REQ-032 Enter 9,0, start with SEC_CLAMP_EN -> sec_tens=5, sec_ones=9 at loadn low; without it -> 9,0.
REQ-033 Same cycle: cancel+start+press key 4 -> IDLE, digits 0, no loadn pulse; start+key 4 in ENTRY -> LOAD, digit dropped.
REQ-034 In ARMED press 8 -> digits 0,0,0,8, digit_cnt 1, armed 0; start held high 20 cycles -> one loadn pulse.
REQ-035 Assert clr during LOAD cycle -> loadn 1 and all outputs 0 without waiting for clk.
